// File: rtl/catapult_shim.sv
// Catapult host shim: PCIe stream loopback FIFO, soft-register MMIO file and a
// single-outstanding UMI memory-request engine driven from those registers.
module catapult_shim #(
    parameter int PCIE_WIDTH         = 256,
    parameter int SOFTREG_ADDR_WIDTH = 32,
    parameter int SOFTREG_DATA_WIDTH = 64,
    parameter int UMI_ADDR_WIDTH     = 64,
    parameter int UMI_DATA_WIDTH     = 512
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          io_pcie_in_valid,
    output logic                          io_pcie_in_ready,
    input  logic [PCIE_WIDTH-1:0]         io_pcie_in_bits,
    output logic                          io_pcie_out_valid,
    input  logic                          io_pcie_out_ready,
    output logic [PCIE_WIDTH-1:0]         io_pcie_out_bits,
    input  logic                          io_softreg_req_valid,
    output logic                          io_softreg_req_ready,
    input  logic [SOFTREG_ADDR_WIDTH-1:0] io_softreg_req_bits_addr,
    input  logic [SOFTREG_DATA_WIDTH-1:0] io_softreg_req_bits_wdata,
    input  logic                          io_softreg_req_bits_wr,
    output logic                          io_softreg_resp_valid,
    input  logic                          io_softreg_resp_ready,
    output logic [SOFTREG_DATA_WIDTH-1:0] io_softreg_resp_bits_rdata,
    output logic                          io_umireq_valid,
    input  logic                          io_umireq_ready,
    output logic [UMI_ADDR_WIDTH-1:0]     io_umireq_bits_addr,
    output logic [UMI_DATA_WIDTH-1:0]     io_umireq_bits_data,
    output logic                          io_umireq_bits_isWrite,
    input  logic                          io_umiresp_valid,
    output logic                          io_umiresp_ready,
    input  logic [UMI_DATA_WIDTH-1:0]     io_umiresp_bits_data
);

    localparam int NSLICE = UMI_DATA_WIDTH / 64;
    localparam int AW     = SOFTREG_ADDR_WIDTH;
    localparam int DW     = SOFTREG_DATA_WIDTH;
    localparam logic [AW-4:0] HI_REGS  = (AW-3)'(0);
    localparam logic [AW-4:0] HI_WDATA = (AW-3)'(1);
    localparam logic [AW-4:0] HI_RDATA = (AW-3)'(2);

    typedef enum logic [1:0] {UMI_IDLE, UMI_REQ, UMI_WAIT} umi_state_e;

    // ---------------- PCIe loopback FIFO ----------------
    logic [PCIE_WIDTH-1:0] fifo_mem_q [4];
    logic [PCIE_WIDTH-1:0] fifo_mem_d [4];
    logic [1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [2:0]  fifo_cnt_q, fifo_cnt_d;
    logic [31:0] in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
    logic        pcie_enq, pcie_deq;

    // Ready is gated by reset so it reads 0 while the block is held in reset.
    assign io_pcie_in_ready  = reset && (fifo_cnt_q != 3'd4);
    assign io_pcie_out_valid = (fifo_cnt_q != 3'd0);
    assign io_pcie_out_bits  = fifo_mem_q[rd_ptr_q];
    assign pcie_enq = io_pcie_in_valid && io_pcie_in_ready;
    assign pcie_deq = io_pcie_out_valid && io_pcie_out_ready;

    always_comb begin
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        in_cnt_d   = in_cnt_q;
        out_cnt_d  = out_cnt_q;
        if (pcie_enq) begin
            fifo_mem_d[wr_ptr_q] = io_pcie_in_bits;
            wr_ptr_d = wr_ptr_q + 2'd1;
            in_cnt_d = in_cnt_q + 32'd1;
        end
        if (pcie_deq) begin
            rd_ptr_d  = rd_ptr_q + 2'd1;
            out_cnt_d = out_cnt_q + 32'd1;
        end
        case ({pcie_enq, pcie_deq})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 3'd1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 3'd1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    // ---------------- Soft registers ----------------
    logic [63:0]               scratch_q, scratch_d;
    logic [UMI_ADDR_WIDTH-1:0] umi_addr_q, umi_addr_d;
    logic [UMI_DATA_WIDTH-1:0] umi_wdata_q, umi_wdata_d;
    logic [UMI_DATA_WIDTH-1:0] umi_rdata_q, umi_rdata_d;
    logic [31:0]               done_cnt_q, done_cnt_d;
    logic                      resp_valid_q, resp_valid_d;
    logic [DW-1:0]             resp_rdata_q, resp_rdata_d;
    logic [AW-4:0]             sr_hi;
    logic [2:0]                sr_lo;
    logic                      sr_accept, sr_wr, sr_rd, cmd_launch;
    logic [63:0]               slice_w, slice_r;
    logic [DW-1:0]             rd_val;

    umi_state_e                state_q, state_d;
    logic [UMI_ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
    logic [UMI_DATA_WIDTH-1:0] req_data_q, req_data_d;
    logic                      req_wr_q, req_wr_d;

    assign io_softreg_req_ready       = reset && !resp_valid_q;
    assign io_softreg_resp_valid      = resp_valid_q;
    assign io_softreg_resp_bits_rdata = resp_rdata_q;

    assign sr_hi      = io_softreg_req_bits_addr[AW-1:3];
    assign sr_lo      = io_softreg_req_bits_addr[2:0];
    assign sr_accept  = io_softreg_req_valid && io_softreg_req_ready;
    assign sr_wr      = sr_accept && io_softreg_req_bits_wr;
    assign sr_rd      = sr_accept && !io_softreg_req_bits_wr;
    assign cmd_launch = sr_wr && (sr_hi == HI_REGS) && (sr_lo == 3'd3);

    always_comb begin
        slice_w = '0;
        slice_r = '0;
        rd_val  = '0;
        // Slices past the configured UMI data width stay 0.
        for (int s = 0; s < NSLICE; s++) begin
            if (sr_lo == 3'(s)) begin
                slice_w = umi_wdata_q[64*s +: 64];
                slice_r = umi_rdata_q[64*s +: 64];
            end
        end
        if (sr_hi == HI_REGS) begin
            case (sr_lo)
                3'd0:    rd_val = DW'(scratch_q);
                3'd1:    rd_val = DW'({fifo_cnt_q, (state_q == UMI_WAIT), (state_q != UMI_IDLE)});
                3'd2:    rd_val = DW'(umi_addr_q);
                3'd4:    rd_val = DW'(in_cnt_q);
                3'd5:    rd_val = DW'(out_cnt_q);
                3'd6:    rd_val = DW'(done_cnt_q);
                default: rd_val = '0;
            endcase
        end else if (sr_hi == HI_WDATA) begin
            rd_val = DW'(slice_w);
        end else if (sr_hi == HI_RDATA) begin
            rd_val = DW'(slice_r);
        end
    end

    always_comb begin
        scratch_d    = scratch_q;
        umi_addr_d   = umi_addr_q;
        umi_wdata_d  = umi_wdata_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        if (sr_wr && (sr_hi == HI_REGS) && (sr_lo == 3'd0)) begin
            scratch_d = io_softreg_req_bits_wdata[63:0];
        end
        if (sr_wr && (sr_hi == HI_REGS) && (sr_lo == 3'd2)) begin
            umi_addr_d = io_softreg_req_bits_wdata[UMI_ADDR_WIDTH-1:0];
        end
        if (sr_wr && (sr_hi == HI_WDATA)) begin
            for (int s = 0; s < NSLICE; s++) begin
                if (sr_lo == 3'(s)) begin
                    umi_wdata_d[64*s +: 64] = io_softreg_req_bits_wdata[63:0];
                end
            end
        end
        if (resp_valid_q && io_softreg_resp_ready) begin
            resp_valid_d = 1'b0;
        end
        if (sr_rd) begin
            resp_valid_d = 1'b1;
            resp_rdata_d = rd_val;
        end
    end

    // ---------------- UMI request engine ----------------
    assign io_umireq_valid        = (state_q == UMI_REQ);
    assign io_umireq_bits_addr    = req_addr_q;
    assign io_umireq_bits_data    = req_data_q;
    assign io_umireq_bits_isWrite = req_wr_q;
    assign io_umiresp_ready       = (state_q == UMI_WAIT);

    always_comb begin
        state_d     = state_q;
        req_addr_d  = req_addr_q;
        req_data_d  = req_data_q;
        req_wr_d    = req_wr_q;
        done_cnt_d  = done_cnt_q;
        umi_rdata_d = umi_rdata_q;
        case (state_q)
            UMI_IDLE: begin
                // Operands are snapshotted so later register writes cannot disturb an in-flight request.
                if (cmd_launch) begin
                    state_d    = UMI_REQ;
                    req_addr_d = umi_addr_q;
                    req_data_d = umi_wdata_q;
                    req_wr_d   = io_softreg_req_bits_wdata[0];
                end
            end
            UMI_REQ: begin
                if (io_umireq_ready) begin
                    if (req_wr_q) begin
                        state_d    = UMI_IDLE;
                        done_cnt_d = done_cnt_q + 32'd1;
                    end else begin
                        state_d = UMI_WAIT;
                    end
                end
            end
            UMI_WAIT: begin
                if (io_umiresp_valid) begin
                    state_d     = UMI_IDLE;
                    umi_rdata_d = io_umiresp_bits_data;
                    done_cnt_d  = done_cnt_q + 32'd1;
                end
            end
            default: state_d = UMI_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) fifo_mem_q[i] <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_cnt_q   <= '0;
            in_cnt_q     <= '0;
            out_cnt_q    <= '0;
            scratch_q    <= '0;
            umi_addr_q   <= '0;
            umi_wdata_q  <= '0;
            umi_rdata_q  <= '0;
            done_cnt_q   <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            state_q      <= UMI_IDLE;
            req_addr_q   <= '0;
            req_data_q   <= '0;
            req_wr_q     <= 1'b0;
        end else begin
            fifo_mem_q   <= fifo_mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_cnt_q   <= fifo_cnt_d;
            in_cnt_q     <= in_cnt_d;
            out_cnt_q    <= out_cnt_d;
            scratch_q    <= scratch_d;
            umi_addr_q   <= umi_addr_d;
            umi_wdata_q  <= umi_wdata_d;
            umi_rdata_q  <= umi_rdata_d;
            done_cnt_q   <= done_cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            state_q      <= state_d;
            req_addr_q   <= req_addr_d;
            req_data_q   <= req_data_d;
            req_wr_q     <= req_wr_d;
        end
    end

endmodule

// File: tb/tb_catapult_shim.sv
// Bench for catapult_shim: directed steps plus randomized traffic checked
// against a queue/array reference model of the host-visible behaviour.
module tb_catapult_shim;

    logic         clock;
    logic         reset;
    logic         io_pcie_in_valid;
    logic         io_pcie_in_ready;
    logic [255:0] io_pcie_in_bits;
    logic         io_pcie_out_valid;
    logic         io_pcie_out_ready;
    logic [255:0] io_pcie_out_bits;
    logic         io_softreg_req_valid;
    logic         io_softreg_req_ready;
    logic [31:0]  io_softreg_req_bits_addr;
    logic [63:0]  io_softreg_req_bits_wdata;
    logic         io_softreg_req_bits_wr;
    logic         io_softreg_resp_valid;
    logic         io_softreg_resp_ready;
    logic [63:0]  io_softreg_resp_bits_rdata;
    logic         io_umireq_valid;
    logic         io_umireq_ready;
    logic [63:0]  io_umireq_bits_addr;
    logic [511:0] io_umireq_bits_data;
    logic         io_umireq_bits_isWrite;
    logic         io_umiresp_valid;
    logic         io_umiresp_ready;
    logic [511:0] io_umiresp_bits_data;

    catapult_shim dut (
        .clock                      (clock),
        .reset                      (reset),
        .io_pcie_in_valid           (io_pcie_in_valid),
        .io_pcie_in_ready           (io_pcie_in_ready),
        .io_pcie_in_bits            (io_pcie_in_bits),
        .io_pcie_out_valid          (io_pcie_out_valid),
        .io_pcie_out_ready          (io_pcie_out_ready),
        .io_pcie_out_bits           (io_pcie_out_bits),
        .io_softreg_req_valid       (io_softreg_req_valid),
        .io_softreg_req_ready       (io_softreg_req_ready),
        .io_softreg_req_bits_addr   (io_softreg_req_bits_addr),
        .io_softreg_req_bits_wdata  (io_softreg_req_bits_wdata),
        .io_softreg_req_bits_wr     (io_softreg_req_bits_wr),
        .io_softreg_resp_valid      (io_softreg_resp_valid),
        .io_softreg_resp_ready      (io_softreg_resp_ready),
        .io_softreg_resp_bits_rdata (io_softreg_resp_bits_rdata),
        .io_umireq_valid            (io_umireq_valid),
        .io_umireq_ready            (io_umireq_ready),
        .io_umireq_bits_addr        (io_umireq_bits_addr),
        .io_umireq_bits_data        (io_umireq_bits_data),
        .io_umireq_bits_isWrite     (io_umireq_bits_isWrite),
        .io_umiresp_valid           (io_umiresp_valid),
        .io_umiresp_ready           (io_umiresp_ready),
        .io_umiresp_bits_data       (io_umiresp_bits_data)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    logic [255:0] exp_q[$];
    logic [31:0]  m_in_cnt, m_out_cnt, m_done;
    logic [63:0]  m_scratch, m_uaddr;
    logic [63:0]  m_wdata [8];
    logic [63:0]  m_rdata [8];
    int           m_state;  // 0 idle, 1 request outstanding, 2 awaiting read data
    logic [63:0]  m_req_addr;
    logic [511:0] m_req_data;
    logic         m_req_wr;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic model_reset();
        exp_q.delete();
        m_in_cnt = 0; m_out_cnt = 0; m_done = 0;
        m_scratch = 0; m_uaddr = 0;
        for (int k = 0; k < 8; k++) begin
            m_wdata[k] = 0;
            m_rdata[k] = 0;
        end
        m_state = 0; m_req_addr = 0; m_req_data = 0; m_req_wr = 0;
    endtask

    function automatic logic [63:0] exp_reg(input logic [31:0] a);
        if (a >= 8 && a < 16) return m_wdata[a - 8];
        if (a >= 16 && a < 24) return m_rdata[a - 16];
        case (a)
            32'd0:   return m_scratch;
            32'd1:   return {59'd0, 3'(exp_q.size()), m_state == 2, m_state != 0};
            32'd2:   return m_uaddr;
            32'd4:   return {32'd0, m_in_cnt};
            32'd5:   return {32'd0, m_out_cnt};
            32'd6:   return {32'd0, m_done};
            default: return 64'd0;
        endcase
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [63:0] d);
        if (a >= 8 && a < 16) m_wdata[a - 8] = d;
        if (a == 0) m_scratch = d;
        if (a == 2) m_uaddr = d;
        if (a == 3 && m_state == 0) begin
            m_state    = 1;
            m_req_addr = m_uaddr;
            for (int k = 0; k < 8; k++) m_req_data[64*k +: 64] = m_wdata[k];
            m_req_wr   = d[0];
        end
    endtask

    // ---------------- scoreboard compare ----------------
    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_req_ready();
        for (int i = 0; i < 16 && !io_softreg_req_ready; i++) @(negedge clock);
        chk("sr_req_ready", io_softreg_req_ready, 1);
    endtask

    task automatic sr_write(input logic [31:0] a, input logic [63:0] d);
        io_softreg_req_valid      = 1'b1;
        io_softreg_req_bits_wr    = 1'b1;
        io_softreg_req_bits_addr  = a;
        io_softreg_req_bits_wdata = d;
        wait_req_ready();
        @(negedge clock);
        io_softreg_req_valid = 1'b0;
        model_write(a, d);
        chk("sr_wr_no_resp", io_softreg_resp_valid, 0);
    endtask

    task automatic sr_read(input logic [31:0] a, output logic [63:0] d);
        io_softreg_req_valid      = 1'b1;
        io_softreg_req_bits_wr    = 1'b0;
        io_softreg_req_bits_addr  = a;
        io_softreg_req_bits_wdata = {$urandom, $urandom};
        wait_req_ready();
        chk("sr_resp_idle", io_softreg_resp_valid, 0);
        @(negedge clock);
        io_softreg_req_valid = 1'b0;
        chk("sr_resp_latency", io_softreg_resp_valid, 1);
        chk("sr_req_blocked", io_softreg_req_ready, 0);
        d = io_softreg_resp_bits_rdata;
        io_softreg_resp_ready = 1'b1;
        @(negedge clock);
        io_softreg_resp_ready = 1'b0;
        chk("sr_resp_drop", io_softreg_resp_valid, 0);
    endtask

    task automatic sr_check(input string tag, input logic [31:0] a);
        logic [63:0] d;
        sr_read(a, d);
        chk(tag, d, exp_reg(a));
    endtask

    // One clock of PCIe traffic: check outputs against the model, then advance both.
    task automatic fifo_cycle(output bit acc);
        bit deq;
        chk("pcie_out_valid", io_pcie_out_valid, exp_q.size() != 0);
        chk("pcie_in_ready", io_pcie_in_ready, exp_q.size() < 4);
        if (exp_q.size() != 0) chk("pcie_out_bits", io_pcie_out_bits, exp_q[0]);
        acc = io_pcie_in_valid && (exp_q.size() < 4);
        deq = io_pcie_out_ready && (exp_q.size() != 0);
        @(negedge clock);
        if (deq) begin
            void'(exp_q.pop_front());
            m_out_cnt++;
        end
        if (acc) begin
            exp_q.push_back(io_pcie_in_bits);
            m_in_cnt++;
        end
    endtask

    function automatic logic [255:0] rand_beat();
        logic [255:0] b;
        for (int w = 0; w < 8; w++) b[32*w +: 32] = $urandom;
        return b;
    endfunction

    task automatic check_req();
        chk("umireq_valid", io_umireq_valid, 1);
        chk("umireq_addr", io_umireq_bits_addr, m_req_addr);
        chk("umireq_data", io_umireq_bits_data, m_req_data);
        chk("umireq_iswrite", io_umireq_bits_isWrite, m_req_wr);
    endtask

    task automatic umi_op(input bit wr, input int req_dly, input int resp_dly,
                          input logic [511:0] rd, input bit poke);
        sr_write(3, {63'd0, wr});
        check_req();
        if (poke) sr_check("status_busy", 1);
        for (int i = 0; i < req_dly; i++) begin
            check_req();
            @(negedge clock);
        end
        check_req();
        io_umireq_ready = 1'b1;
        @(negedge clock);
        io_umireq_ready = 1'b0;
        if (wr) begin
            m_done++;
            m_state = 0;
        end else begin
            m_state = 2;
        end
        chk("umireq_drop", io_umireq_valid, 0);
        if (!wr) begin
            chk("umiresp_ready_hi", io_umiresp_ready, 1);
            if (poke) begin
                sr_write(3, 64'd1);
                sr_check("status_pending", 1);
                chk("umireq_busy_ignored", io_umireq_valid, 0);
            end
            for (int i = 0; i < resp_dly; i++) @(negedge clock);
            io_umiresp_valid     = 1'b1;
            io_umiresp_bits_data = rd;
            @(negedge clock);
            io_umiresp_valid = 1'b0;
            for (int k = 0; k < 8; k++) m_rdata[k] = rd[64*k +: 64];
            m_done++;
            m_state = 0;
            chk("umiresp_ready_lo", io_umiresp_ready, 0);
        end
        sr_check("status_idle", 1);
        sr_check("done_cnt", 6);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit           acc;
        logic [511:0] rd;
        logic [31:0]  a;

        reset = 1'b0;
        io_pcie_in_valid = 0; io_pcie_in_bits = 0; io_pcie_out_ready = 0;
        io_softreg_req_valid = 0; io_softreg_req_bits_addr = 0;
        io_softreg_req_bits_wdata = 0; io_softreg_req_bits_wr = 0;
        io_softreg_resp_ready = 0; io_umireq_ready = 0;
        io_umiresp_valid = 0; io_umiresp_bits_data = 0;
        model_reset();

        repeat (2) @(negedge clock);
        chk("rst_in_ready", io_pcie_in_ready, 0);
        chk("rst_req_ready", io_softreg_req_ready, 0);
        chk("rst_out_valid", io_pcie_out_valid, 0);
        chk("rst_umireq_valid", io_umireq_valid, 0);
        chk("rst_umiresp_ready", io_umiresp_ready, 0);
        reset = 1'b1;
        #1;
        chk("rel_in_ready", io_pcie_in_ready, 1);
        chk("rel_req_ready", io_softreg_req_ready, 1);

        // Basic register access
        sr_check("status_after_reset", 1);
        sr_write(0, 64'hDEADBEEF_CAFEF00D);
        sr_check("scratch_rw", 0);
        sr_check("cmd_reads_zero", 3);

        // Push 1..5 with the consumer stalled, then drain in order
        io_pcie_out_ready = 1'b0;
        for (int b = 1; b <= 4; b++) begin
            io_pcie_in_valid = 1'b1;
            io_pcie_in_bits  = 256'(b);
            fifo_cycle(acc);
        end
        io_pcie_in_bits = 256'd5;
        repeat (2) fifo_cycle(acc);
        io_pcie_out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            fifo_cycle(acc);
            if (acc) io_pcie_in_valid = 1'b0;
        end
        io_pcie_out_ready = 1'b0;
        sr_check("pcie_in_cnt_5", 4);
        sr_check("pcie_out_cnt_5", 5);

        // Back-to-back streaming
        io_pcie_in_valid  = 1'b1;
        io_pcie_out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            io_pcie_in_bits = 256'(i + 1000);
            fifo_cycle(acc);
        end
        io_pcie_in_valid = 1'b0;
        repeat (3) fifo_cycle(acc);
        io_pcie_out_ready = 1'b0;
        sr_check("pcie_in_cnt_stream", 4);
        sr_check("pcie_out_cnt_stream", 5);

        // Random PCIe traffic; a pending beat is held until accepted
        io_pcie_in_valid = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!io_pcie_in_valid || acc) begin
                io_pcie_in_valid = 1'($urandom_range(0, 1));
                io_pcie_in_bits  = rand_beat();
            end
            io_pcie_out_ready = 1'($urandom_range(0, 1));
            fifo_cycle(acc);
        end
        io_pcie_in_valid  = 1'b0;
        io_pcie_out_ready = 1'b1;
        repeat (6) fifo_cycle(acc);
        io_pcie_out_ready = 1'b0;
        sr_check("status_fifo_drained", 1);

        // Random register traffic, including unmapped and read-only targets
        for (int i = 0; i < 40; i++) begin
            a = ($urandom_range(0, 5) == 0) ? $urandom : 32'($urandom_range(0, 27));
            if ($urandom_range(0, 1) == 1 && a != 3) sr_write(a, {$urandom, $urandom});
            else sr_check("rand_reg", a);
        end

        // Read data offered while idle must not be consumed
        io_umiresp_valid     = 1'b1;
        io_umiresp_bits_data = {16{32'hFFFF_FFFF}};
        @(negedge clock);
        chk("umiresp_idle_ready", io_umiresp_ready, 0);
        @(negedge clock);
        io_umiresp_valid = 1'b0;
        sr_check("rdata_untouched", 16);

        // Directed UMI write and read
        sr_write(2, 64'h1000);
        sr_write(8, 64'h11);
        umi_op(1'b1, 3, 0, '0, 1'b1);
        for (int w = 0; w < 16; w++) rd[32*w +: 32] = $urandom;
        rd[191:128] = 64'hAB;
        umi_op(1'b0, 1, 5, rd, 1'b1);
        sr_check("rdata_slice2", 32'h12);

        // Random UMI operations
        for (int n = 0; n < 6; n++) begin
            sr_write(2, {$urandom, $urandom});
            for (int k = 0; k < 8; k++) sr_write(32'(8 + k), {$urandom, $urandom});
            for (int w = 0; w < 16; w++) rd[32*w +: 32] = $urandom;
            umi_op(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 4), rd, 1'b0);
            sr_check("rand_rdata", 32'($urandom_range(16, 23)));
        end

        // Reset with two beats queued, a UMI read outstanding and a register response pending
        io_pcie_in_valid = 1'b1;
        io_pcie_in_bits  = rand_beat();
        fifo_cycle(acc);
        io_pcie_in_bits  = rand_beat();
        fifo_cycle(acc);
        io_pcie_in_valid = 1'b0;
        sr_write(3, 64'd0);
        check_req();
        io_umireq_ready = 1'b1;
        @(negedge clock);
        io_umireq_ready = 1'b0;
        m_state = 2;
        chk("pre_rst_umiresp_ready", io_umiresp_ready, 1);
        chk("pre_rst_out_valid", io_pcie_out_valid, 1);
        io_softreg_req_valid     = 1'b1;
        io_softreg_req_bits_wr   = 1'b0;
        io_softreg_req_bits_addr = 32'd0;
        @(negedge clock);
        io_softreg_req_valid = 1'b0;
        chk("pre_rst_resp_valid", io_softreg_resp_valid, 1);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_in_ready", io_pcie_in_ready, 0);
        chk("mid_rst_out_valid", io_pcie_out_valid, 0);
        chk("mid_rst_out_bits", io_pcie_out_bits, 0);
        chk("mid_rst_req_ready", io_softreg_req_ready, 0);
        chk("mid_rst_resp_valid", io_softreg_resp_valid, 0);
        chk("mid_rst_resp_data", io_softreg_resp_bits_rdata, 0);
        chk("mid_rst_umireq_valid", io_umireq_valid, 0);
        chk("mid_rst_umireq_addr", io_umireq_bits_addr, 0);
        chk("mid_rst_umireq_data", io_umireq_bits_data, 0);
        chk("mid_rst_umireq_wr", io_umireq_bits_isWrite, 0);
        chk("mid_rst_umiresp_ready", io_umiresp_ready, 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        model_reset();
        #1;
        chk("post_rst_in_ready", io_pcie_in_ready, 1);
        chk("post_rst_req_ready", io_softreg_req_ready, 1);
        chk("post_rst_out_valid", io_pcie_out_valid, 0);
        chk("post_rst_umiresp_ready", io_umiresp_ready, 0);
        sr_check("post_rst_status", 1);
        sr_check("post_rst_in_cnt", 4);
        sr_check("post_rst_done_cnt", 6);
        sr_check("post_rst_scratch", 0);
        sr_check("post_rst_rdata2", 32'h12);

        // ---------------- report ----------------
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
